// File: rtl/booth_pp_accum_if.sv
// -----------------------------------------------------------------------------
// booth_pp_accum_if
// Handshake bundle between a Booth partial-product source, the accumulator and
// the product consumer.
//   pp_in/pp_valid/pp_ready          : partial-product beat channel
//   prod_out/prod_valid/prod_ready   : finished product channel
//   beat_idx                         : index of the next beat to be accepted
//   abort                            : only with BOOTH_PP_ACCUM_ABORT_EN defined
// Modports: master = producer/consumer side, slave = accumulator side.
// -----------------------------------------------------------------------------
interface booth_pp_accum_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_PP = 4
);
  localparam int IDX_W = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

  logic [WIDTH-1:0] pp_in;
  logic             pp_valid;
  logic             pp_ready;
  logic [WIDTH-1:0] prod_out;
  logic             prod_valid;
  logic             prod_ready;
  logic [IDX_W-1:0] beat_idx;
`ifdef BOOTH_PP_ACCUM_ABORT_EN
  logic             abort;

  modport master (
    output pp_in, pp_valid, prod_ready, abort,
    input  pp_ready, prod_out, prod_valid, beat_idx
  );
  modport slave (
    input  pp_in, pp_valid, prod_ready, abort,
    output pp_ready, prod_out, prod_valid, beat_idx
  );
`else
  modport master (
    output pp_in, pp_valid, prod_ready,
    input  pp_ready, prod_out, prod_valid, beat_idx
  );
  modport slave (
    input  pp_in, pp_valid, prod_ready,
    output pp_ready, prod_out, prod_valid, beat_idx
  );
`endif
endinterface

// File: rtl/booth_pp_accum.sv
// -----------------------------------------------------------------------------
// booth_pp_accum
// Accumulates NUM_PP sign-extended radix-4 Booth partial products (one per beat,
// digit order k = 0..NUM_PP-1). Beat k is shifted left by SHIFT*k, truncated to
// WIDTH bits and added modulo 2^WIDTH. After the last beat the product is held
// on a valid/ready output until taken; only then are new beats accepted.
// Ports:
//   clk    : clock, rising edge
//   clr_n  : asynchronous active-low clear of all state
//   bus    : booth_pp_accum_if.slave (beat channel, product channel, beat_idx)
// Optional feature: define BOOTH_PP_ACCUM_ABORT_EN to add bus.abort, a
// synchronous active-high abort that discards the multiply in progress (or the
// pending product) and has priority over both handshakes.
// -----------------------------------------------------------------------------
module booth_pp_accum #(
  parameter int WIDTH  = 16,
  parameter int NUM_PP = 4,
  parameter int SHIFT  = 2
) (
  input logic             clk,
  input logic             clr_n,
  booth_pp_accum_if.slave bus
);
  localparam int                 IDX_W    = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_PP - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] beat_idx_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] prod_out_q;
  logic             prod_valid_q;
  logic             pp_ready_q;

  logic [WIDTH-1:0] term_d;
  logic [WIDTH-1:0] sum_d;
  logic             beat_take;
  logic             abort_req;

  // One pre-aligned copy of the incoming beat per digit position; the current
  // beat index then just selects one, keeping the shifter out of the add path.
  logic [WIDTH-1:0] aligned [NUM_PP];

  generate
    for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_align
      assign aligned[gi] = bus.pp_in << (SHIFT * gi);
    end
  endgenerate

`ifdef BOOTH_PP_ACCUM_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    term_d = aligned[beat_idx_q];
    // Beat 0 starts a fresh sum, so a stale accumulator never leaks in.
    sum_d  = ((beat_idx_q == '0) ? '0 : acc_q) + term_d;
  end

  // pp_ready_q only rises in ACC, so acceptance never depends on pp_valid
  // feeding back into pp_ready.
  assign beat_take = bus.pp_valid && pp_ready_q && (state_q == ST_ACC);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= ST_ACC;
      beat_idx_q   <= '0;
      acc_q        <= '0;
      prod_out_q   <= '0;
      prod_valid_q <= 1'b0;
      pp_ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          pp_ready_q <= 1'b1;
          if (abort_req) begin
            beat_idx_q <= '0;
            acc_q      <= '0;
          end else if (beat_take) begin
            if (beat_idx_q == LAST_IDX) begin
              prod_out_q   <= sum_d;
              prod_valid_q <= 1'b1;
              beat_idx_q   <= '0;
              pp_ready_q   <= 1'b0;
              state_q      <= ST_HOLD;
            end else begin
              acc_q      <= sum_d;
              beat_idx_q <= beat_idx_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // pp_ready rises with the handshake edge, so the next multiply's
          // first beat lands one cycle later at the earliest.
          if (abort_req || (prod_valid_q && bus.prod_ready)) begin
            prod_valid_q <= 1'b0;
            pp_ready_q   <= 1'b1;
            state_q      <= ST_ACC;
          end
        end
        default: begin
          state_q <= ST_ACC;
        end
      endcase
    end
  end

  assign bus.pp_ready   = pp_ready_q;
  assign bus.prod_out   = prod_out_q;
  assign bus.prod_valid = prod_valid_q;
  assign bus.beat_idx   = beat_idx_q;

endmodule

// File: tb/tb_booth_pp_accum.sv
// -----------------------------------------------------------------------------
// tb_booth_pp_accum
// Self-checking bench for booth_pp_accum: directed cases plus randomized
// multiplies compared against a plain-arithmetic reference of the shifted sum.
// Define BOOTH_PP_ACCUM_ABORT_EN to also exercise the abort input.
// -----------------------------------------------------------------------------
module tb_booth_pp_accum;
  localparam int WIDTH  = 16;
  localparam int NUM_PP = 4;
  localparam int SHIFT  = 2;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  booth_pp_accum_if #(.WIDTH(WIDTH), .NUM_PP(NUM_PP)) bus ();

  booth_pp_accum #(.WIDTH(WIDTH), .NUM_PP(NUM_PP), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int mul_no = 0;
  int rises = 0;
  logic pv_prev = 1'b0;

  logic [WIDTH-1:0] bv [NUM_PP];

  // Counts rising edges of prod_valid (one per delivered product).
  always @(posedge clk) begin
    if (bus.prod_valid && !pv_prev) rises <= rises + 1;
    pv_prev <= bus.prod_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: product = sum_k (beat_k * 2^(SHIFT*k)) mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] model_product();
    logic [63:0] s;
    s = 64'd0;
    for (int k = 0; k < NUM_PP; k++) s = s + ({48'd0, bv[k]} << (SHIFT * k));
    return s[WIDTH-1:0];
  endfunction

  task automatic send_beat(input logic [WIDTH-1:0] v, input int k);
    int n;
    n = 0;
    bus.pp_in    = v;
    bus.pp_valid = 1'b1;
    while (!bus.pp_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.pp_ready) check("ready_timeout", 32'd0, 32'd1);
    check($sformatf("beat_idx_k%0d", k), 32'(bus.beat_idx), 32'(k));
    check($sformatf("early_valid_k%0d", k), 32'(bus.prod_valid), 32'd0);
    tick();
  endtask

  task automatic run_mul(input string name, input logic [WIDTH-1:0] exp_v,
                         input int hold, input bit gaps);
    int idle;
    for (int k = 0; k < NUM_PP; k++) begin
      send_beat(bv[k], k);
      if (gaps && k < NUM_PP - 1 && $urandom_range(0, 1) == 1) begin
        bus.pp_valid = 1'b0;
        bus.pp_in    = 16'($urandom);
        idle = int'($urandom_range(1, 3));
        repeat (idle) tick();
        check({name, "_gap_idx"}, 32'(bus.beat_idx), 32'(k + 1));
      end
    end
    check({name, "_valid"}, 32'(bus.prod_valid), 32'd1);
    check({name, "_prod"}, 32'(bus.prod_out), 32'(exp_v));
    check({name, "_ready_hold"}, 32'(bus.pp_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.pp_valid = 1'($urandom_range(0, 1));
      bus.pp_in    = 16'($urandom);
      tick();
      check({name, "_bp_prod"}, 32'(bus.prod_out), 32'(exp_v));
      check({name, "_bp_valid"}, 32'(bus.prod_valid), 32'd1);
      check({name, "_bp_ready"}, 32'(bus.pp_ready), 32'd0);
      check({name, "_bp_idx"}, 32'(bus.beat_idx), 32'd0);
    end
    bus.pp_valid   = 1'b0;
    bus.prod_ready = 1'b1;
    tick();
    bus.prod_ready = 1'b0;
    check({name, "_hs_valid"}, 32'(bus.prod_valid), 32'd0);
    check({name, "_hs_ready"}, 32'(bus.pp_ready), 32'd1);
    check({name, "_retained"}, 32'(bus.prod_out), 32'(exp_v));
    mul_no++;
    $display("mul %0d %s: beats %04h %04h %04h %04h -> prod=%04h expected=%04h",
             mul_no, name, bv[0], bv[1], bv[2], bv[3], bus.prod_out, exp_v);
  endtask

  initial begin
    clr_n          = 1'b0;
    bus.pp_in      = '0;
    bus.pp_valid   = 1'b0;
    bus.prod_ready = 1'b0;
`ifdef BOOTH_PP_ACCUM_ABORT_EN
    bus.abort      = 1'b0;
`endif
    tick();
    tick();
    check("rst_valid", 32'(bus.prod_valid), 32'd0);
    check("rst_prod", 32'(bus.prod_out), 32'd0);
    check("rst_idx", 32'(bus.beat_idx), 32'd0);
    check("rst_ready", 32'(bus.pp_ready), 32'd0);
    clr_n = 1'b1;
    tick();
    check("rel_ready", 32'(bus.pp_ready), 32'd1);

    // 7 x -3
    bv[0] = 16'h0007; bv[1] = 16'hFFF9; bv[2] = 16'h0000; bv[3] = 16'h0000;
    run_mul("7x-3", 16'hFFEB, 0, 1'b0);
    // Shift alignment
    bv[0] = 16'h0001; bv[1] = 16'h0001; bv[2] = 16'h0001; bv[3] = 16'h0001;
    run_mul("shift", 16'h0055, 0, 1'b0);
    // Silent wrap
    bv[0] = 16'h0000; bv[1] = 16'h4000; bv[2] = 16'h0000; bv[3] = 16'h0000;
    run_mul("wrap", 16'h0000, 0, 1'b0);
    // Backpressure for 5 cycles
    bv[0] = 16'h0123; bv[1] = 16'hFF00; bv[2] = 16'h0011; bv[3] = 16'hFFFE;
    run_mul("backpr", model_product(), 5, 1'b0);

    // Asynchronous clear in the middle of a multiply
    bv[0] = 16'h0AAA; bv[1] = 16'h0BBB;
    send_beat(bv[0], 0);
    send_beat(bv[1], 1);
    bus.pp_valid = 1'b0;
    #2;
    clr_n = 1'b0;
    #1;
    check("midrst_idx", 32'(bus.beat_idx), 32'd0);
    check("midrst_valid", 32'(bus.prod_valid), 32'd0);
    check("midrst_ready", 32'(bus.pp_ready), 32'd0);
    tick();
    clr_n = 1'b1;
    tick();
    check("midrst_rel_ready", 32'(bus.pp_ready), 32'd1);
    bv[0] = 16'h0001; bv[1] = 16'h0001; bv[2] = 16'h0001; bv[3] = 16'h0001;
    run_mul("after_rst", 16'h0055, 0, 1'b0);

`ifdef BOOTH_PP_ACCUM_ABORT_EN
    begin
      int r0;
      send_beat(16'h1234, 0);
      bus.abort    = 1'b1;
      bus.pp_in    = 16'h5555;
      bus.pp_valid = 1'b1;
      tick();
      bus.abort    = 1'b0;
      bus.pp_valid = 1'b0;
      check("abort_idx", 32'(bus.beat_idx), 32'd0);
      check("abort_valid", 32'(bus.prod_valid), 32'd0);
      r0 = rises;
      bv[0] = 16'h0007; bv[1] = 16'hFFF9; bv[2] = 16'h0000; bv[3] = 16'h0000;
      run_mul("abort_7x-3", 16'hFFEB, 0, 1'b0);
      check("abort_pulses", 32'(rises - r0), 32'd1);
      // Abort while a product is pending
      bv[0] = 16'h0003; bv[1] = 16'h0002; bv[2] = 16'h0000; bv[3] = 16'h0000;
      for (int k = 0; k < NUM_PP; k++) send_beat(bv[k], k);
      bus.pp_valid = 1'b0;
      bus.abort    = 1'b1;
      tick();
      bus.abort    = 1'b0;
      check("abort_hold_valid", 32'(bus.prod_valid), 32'd0);
      check("abort_hold_ready", 32'(bus.pp_ready), 32'd1);
      check("abort_hold_prod", 32'(bus.prod_out), 32'(model_product()));
    end
`endif

    // Randomized multiplies with idle gaps and random backpressure
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < NUM_PP; k++) bv[k] = 16'($urandom);
      run_mul("rand", model_product(), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/booth_pp_accum.md
Name: booth_pp_accum

Overview:
- Downstream consumer of the partial-product registers in the 8-bit radix-4 Booth pipeline.
- Accepts one 16-bit sign-extended partial product per beat, in Booth-digit order k = 0..NUM_PP-1.
- Each beat is aligned by left shift of SHIFT*k and summed into a running accumulator.
- After the last beat, presents the WIDTH-bit product on a valid/ready output handshake.

Parameters:
- WIDTH, 16, width of the partial products, accumulator and product.
- NUM_PP, 4, partial products per multiply; one per Booth digit.
- SHIFT, 2, bit shift per digit index; radix-4 gives 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr_n  input  1  asynchronous active-low reset.
- pp_in  input  WIDTH  sign-extended partial product for the current beat.
- pp_valid  input  1  pp_in is valid this cycle.
- pp_ready  output  1  block accepts pp_in this cycle.
- prod_out  output  WIDTH  accumulated product.
- prod_valid  output  1  prod_out is valid.
- prod_ready  input  1  consumer takes prod_out.
- beat_idx  output  clog2(NUM_PP)  index of the next beat to be accepted.

Behaviour:
- Reset: clr_n low asynchronously clears every register, whatever the current state.
  - state = ACC, beat_idx = 0, accumulator = 0, prod_out = 0, prod_valid = 0.
  - pp_ready = 1 from the first edge after release.
- States: ACC and HOLD.
- ACC:
  - pp_ready = 1, prod_valid = 0.
  - A beat is accepted when pp_valid && pp_ready.
  - On acceptance: term = (pp_in << SHIFT*beat_idx) truncated to WIDTH bits.
  - sum = (beat_idx == 0 ? 0 : acc) + term, modulo 2^WIDTH. Overflow wraps silently; no carry out.
  - If beat_idx < NUM_PP-1: acc <= sum, beat_idx increments.
  - If beat_idx == NUM_PP-1: prod_out <= sum, prod_valid <= 1, beat_idx <= 0, state <= HOLD.
  - pp_valid low means no change to any register.
- HOLD:
  - pp_ready = 0; pp_in is ignored.
  - prod_out and prod_valid hold stable until prod_ready.
  - When prod_valid && prod_ready: prod_valid <= 0, state <= ACC.
  - No same-cycle bypass: the first beat of the next multiply is accepted no earlier than the cycle after the handshake.
- Latency: prod_valid rises on the clock edge that accepts the last beat.
- Throughput: one multiply per NUM_PP+1 cycles with continuous valid/ready.
- prod_out retains its last value after consumption until it is overwritten.
- pp_ready is a function of state only; it never depends combinationally on pp_valid.

Optional Feature:
- Macro: BOOTH_PP_ACCUM_ABORT_EN.
- When defined:
  - Adds input abort (1 bit, active-high, synchronous).
  - On an edge with abort = 1 in ACC: beat_idx <= 0, acc <= 0, and any beat presented that cycle is discarded.
  - In HOLD, abort clears prod_valid and returns to ACC.
  - abort has priority over all handshakes.
- When undefined: the port does not exist and behaviour is exactly as above.

Test Plan:
- 7 x -3: beats 0x0007, 0xFFF9, 0x0000, 0x0000 with pp_valid held high -> prod_valid = 1 on the 4th accept edge, prod_out = 0xFFEB (-21).
- Shift check: four beats of 0x0001 -> prod_out = 0x0055.
- Wrap: beats 0x0000, 0x4000, 0x0000, 0x0000 -> prod_out = 0x0000, no error indication.
- Backpressure: prod_ready held low 5 cycles after completion -> prod_out stable, prod_valid = 1, pp_ready = 0 throughout; pp_ready returns to 1 the cycle after the handshake.
- Reset mid-operation: pull clr_n low after 2 accepted beats, then four beats of 0x0001 -> beat_idx reads 0 after reset, prod_out = 0x0055.
- Abort (BOOTH_PP_ACCUM_ABORT_EN defined): abort after beat 1, then beats 0x0007, 0xFFF9, 0, 0 -> prod_out = 0xFFEB, and only one prod_valid pulse.
